// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data words, register ids, opcodes
// and the writeback-stage shutdown state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011
    } opcode_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: register-file write, last-write buffer,
// retire counter (WB_RETIRE_CNT_EN) and halt/flush shutdown.
module wb_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  word_t            pc_add4,
    input  word_t            instruction,
    input  logic             regWr,
    input  logic             memToReg,
    input  regbits_t         regDst,
    input  logic             halt,
    input  word_t            portOut,
    input  word_t            dataWriteVal,
    input  logic             dflushed,
    output logic             rf_WEN,
    output regbits_t         rf_wsel,
    output word_t            rf_wdat,
    output logic             lw_valid,
    output regbits_t         lw_reg,
    output word_t            lw_dat,
    output logic             wb_freeze,
    output logic             dflush_req,
    output logic             halt_out,
    output logic [CNT_W-1:0] retire_count
);

    wb_state_t state_q;
    wb_state_t state_d;
    logic      run;
    logic      retire;

    function automatic word_t wb_data(
        input opcode_t op,
        input logic    m2r,
        input word_t   pc4,
        input word_t   ld,
        input word_t   alu
    );
        word_t d;
        if (op == JAL)
            d = pc4;
        else if (m2r)
            d = ld;
        else
            d = alu;
        return d;
    endfunction

    assign run     = (state_q == RUN);
    assign retire  = run && (instruction != '0);
    assign rf_wsel = regDst;
    assign rf_WEN  = regWr && (regDst != '0) && !halt && run;
    assign rf_wdat = wb_data(opcode_t'(instruction[31:26]),
                             memToReg, pc_add4, portOut,
                             dataWriteVal);

    // Shutdown state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Next state and Moore freeze/flush/halt outputs
    always_comb begin
        state_d    = state_q;
        wb_freeze  = 1'b0;
        dflush_req = 1'b0;
        halt_out   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt)
                    state_d = FLUSH;
            end
            FLUSH: begin
                wb_freeze  = 1'b1;
                dflush_req = 1'b1;
                if (dflushed)
                    state_d = HALTED;
            end
            HALTED: begin
                wb_freeze = 1'b1;
                halt_out  = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // Last-write buffer for decode forwarding
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lw_valid <= 1'b0;
            lw_reg   <= '0;
            lw_dat   <= '0;
        end else if (rf_WEN) begin
            lw_valid <= 1'b1;
            lw_reg   <= rf_wsel;
            lw_dat   <= rf_wdat;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Retired instruction counter, wraps naturally
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign retire_count = cnt_q;
`else
    logic retire_unused;
    assign retire_unused = retire;
    assign retire_count  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table, hand
// sequences and random traffic against a behavioural model.
module tb_wb_stage;
    import cpu_types_pkg::*;

    localparam int CW = 4;
`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [31:0]   pc_add4, instruction, portOut, dataWriteVal;
    logic          regWr, memToReg, halt, dflushed;
    logic [4:0]    regDst;
    logic          rf_WEN, lw_valid, wb_freeze, dflush_req;
    logic          halt_out;
    logic [4:0]    rf_wsel, lw_reg;
    logic [31:0]   rf_wdat, lw_dat;
    logic [CW-1:0] retire_count;

    wb_stage #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .pc_add4(pc_add4),
        .instruction(instruction), .regWr(regWr),
        .memToReg(memToReg), .regDst(regDst), .halt(halt),
        .portOut(portOut), .dataWriteVal(dataWriteVal),
        .dflushed(dflushed), .rf_WEN(rf_WEN),
        .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .lw_valid(lw_valid), .lw_reg(lw_reg), .lw_dat(lw_dat),
        .wb_freeze(wb_freeze), .dflush_req(dflush_req),
        .halt_out(halt_out), .retire_count(retire_count)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: 0 running, 1 flushing, 2 halted
    int          m_state;
    logic        m_lv;
    logic [4:0]  m_lr;
    logic [31:0] m_ld;
    int unsigned m_cnt;

    typedef struct {
        logic [31:0] ins;
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] po;
        logic [31:0] dv;
        logic [31:0] pc;
        logic        wen;
        logic [31:0] wdat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_lv    = 1'b0;
        m_lr    = '0;
        m_ld    = '0;
        m_cnt   = 0;
    endtask

    function automatic logic m_wen();
        return m_state == 0 && regWr && regDst != 0 && !halt;
    endfunction

    function automatic logic [31:0] m_wdat();
        if (instruction[31:26] == 6'b000011)
            return pc_add4;
        if (memToReg)
            return portOut;
        return dataWriteVal;
    endfunction

    task automatic check_all();
        logic [31:0] ec;
        ec = CNT_EN ? 32'(m_cnt % (1 << CW)) : 32'd0;
        chk("rf_WEN", 32'(rf_WEN), 32'(m_wen()));
        chk("rf_wsel", 32'(rf_wsel), 32'(regDst));
        if (m_wen())
            chk("rf_wdat", rf_wdat, m_wdat());
        chk("lw_valid", 32'(lw_valid), 32'(m_lv));
        chk("lw_reg", 32'(lw_reg), 32'(m_lr));
        chk("lw_dat", lw_dat, m_ld);
        chk("wb_freeze", 32'(wb_freeze), 32'(m_state != 0));
        chk("dflush_req", 32'(dflush_req), 32'(m_state == 1));
        chk("halt_out", 32'(halt_out), 32'(m_state == 2));
        chk("retire_count", 32'(retire_count), ec);
    endtask

    task automatic apply(input logic [31:0] ins, input logic rw,
                         input logic m2r, input logic [4:0] rd,
                         input logic h, input logic [31:0] po,
                         input logic [31:0] dv,
                         input logic [31:0] pc, input logic df);
        instruction  = ins;
        regWr        = rw;
        memToReg     = m2r;
        regDst       = rd;
        halt         = h;
        portOut      = po;
        dataWriteVal = dv;
        pc_add4      = pc;
        dflushed     = df;
    endtask

    // clock edge: update model from pre-edge inputs
    task automatic advance();
        logic wen;
        logic [31:0] wd;
        wen = m_wen();
        wd  = m_wdat();
        @(posedge CLK);
        if (wen) begin
            m_lv = 1'b1;
            m_lr = regDst;
            m_ld = wd;
        end
        if (m_state == 0) begin
            if (instruction != 0)
                m_cnt++;
            if (halt)
                m_state = 1;
        end else if (m_state == 1) begin
            if (dflushed)
                m_state = 2;
        end
        @(negedge CLK);
    endtask

    task automatic step(input logic [31:0] ins, input logic rw,
                        input logic m2r, input logic [4:0] rd,
                        input logic h, input logic [31:0] po,
                        input logic [31:0] dv,
                        input logic [31:0] pc, input logic df);
        apply(ins, rw, m2r, rd, h, po, dv, pc, df);
        #1;
        check_all();
        advance();
    endtask

    task automatic rand_step(input logic h, input logic df);
        logic [31:0] ins;
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0)
            ins = 32'd0;
        else if (sel == 1)
            ins = {6'b000011, 26'($urandom)};
        else
            ins = $urandom;
        step(ins, 1'($urandom), 1'($urandom), 5'($urandom), h,
             $urandom, $urandom, $urandom, df);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h8C00_0001, 1, 1, 5'd5, 32'hDEADBEEF,
                   32'h1111_1111, 32'h100, 1, 32'hDEADBEEF};
        tbl[1] = '{{6'b000011, 26'h40}, 1, 0, 5'd31, 32'h5,
                   32'h6, 32'h104, 1, 32'h104};
        tbl[2] = '{32'h0000_0020, 1, 0, 5'd0, 32'h7,
                   32'h8, 32'h108, 0, 32'h8};
        tbl[3] = '{32'h0000_0021, 1, 0, 5'd9, 32'h7,
                   32'hCAFE_0001, 32'h10C, 1, 32'hCAFE_0001};
        tbl[4] = '{{6'b000011, 26'h1}, 1, 1, 5'd31, 32'h9,
                   32'hA, 32'h200, 1, 32'h200};
        tbl[5] = '{32'h0000_0022, 0, 1, 5'd7, 32'h1234,
                   32'hB, 32'h204, 0, 32'h1234};
        tbl[6] = '{32'h0, 0, 0, 5'd0, 32'h0,
                   32'h0, 32'h0, 0, 32'h0};

        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // bubbles after reset: everything idle
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // vector table
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].ins, tbl[i].rw, tbl[i].m2r, tbl[i].rd,
                  1'b0, tbl[i].po, tbl[i].dv, tbl[i].pc, 1'b0);
            #1;
            chk("tbl_wen", 32'(rf_WEN), 32'(tbl[i].wen));
            if (tbl[i].wen)
                chk("tbl_wdat", rf_wdat, tbl[i].wdat);
            check_all();
            advance();
            if (i == 0) begin
                chk("lw_valid_first", 32'(lw_valid), 32'd1);
                chk("lw_reg_first", 32'(lw_reg), 32'd5);
                chk("cnt_first", 32'(retire_count),
                    CNT_EN ? 32'd1 : 32'd0);
            end
        end

        // random traffic in RUN, long enough to wrap the counter
        for (int i = 0; i < 150; i++)
            rand_step(1'b0, 1'($urandom));

        // halt with a write: suppressed, then slow flush
        step(32'hFC00_0000, 1, 0, 5'd3, 1, 0, 32'h55, 0, 0);
        chk("freeze_after_halt", 32'(wb_freeze), 32'd1);
        for (int i = 0; i < 5; i++)
            rand_step(1'($urandom), 1'b0);
        chk("still_flush", 32'(dflush_req), 32'd1);
        rand_step(1'($urandom), 1'b1);
        chk("halt_out_set", 32'(halt_out), 32'd1);
        chk("req_dropped", 32'(dflush_req), 32'd0);
        for (int i = 0; i < 8; i++)
            rand_step(1'($urandom), 1'($urandom));

        // reset mid-flush drops outputs asynchronously
        do_reset();
        step(32'hFC00_0000, 0, 0, 5'd0, 1, 0, 0, 0, 0);
        step(32'h1, 1, 0, 5'd4, 0, 0, 32'h9, 0, 0);
        chk("flush_cycle2", 32'(dflush_req), 32'd1);
        RST = 1'b1;
        #1;
        chk("async_req", 32'(dflush_req), 32'd0);
        chk("async_freeze", 32'(wb_freeze), 32'd0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++)
            rand_step(1'b0, 1'($urandom));

        // dflushed already high: one-cycle flush
        step(32'hFC00_0000, 1, 1, 5'd8, 1, 0, 0, 0, 1);
        chk("short_flush", 32'(dflush_req), 32'd1);
        step(32'h1, 1, 1, 5'd8, 0, 32'h77, 0, 0, 1);
        chk("short_halted", 32'(halt_out), 32'd1);
        for (int i = 0; i < 4; i++)
            rand_step(1'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
